// File: rtl/oam_dma_ctrl.sv
// Sprite (OAM) DMA engine. A W4014 strobe latches a source page, RDY halts
// the CPU, and 256 bytes are copied from $XX00..$XXFF to OAMDATA as
// alternating get (read) / put (write) bus cycles. Gets always land on
// parity-0 cycles; an ALIGN cycle is inserted when the halt ends on the
// wrong parity. All outputs come straight from flops.
module oam_dma_ctrl #(
    parameter logic [15:0] OAM_PORT = 16'h2004,
    parameter int          XFER_LEN = 256
) (
    input  logic        CLK,
    input  logic        n_RES,
    input  logic        W4014,
    input  logic [7:0]  DB_in,
    input  logic        RnW_fromcore,
    output logic        RDY,
    output logic        DMA_Active,
    output logic [15:0] DMA_Addr,
    output logic        DMA_RnW,
    output logic [7:0]  DB_out
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_ALIGN = 3'd2,
        ST_GET   = 3'd3,
        ST_PUT   = 3'd4
    } state_t;

    // Index of the final byte; the transfer ends on the put of this byte.
    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    state_t      r_state;
    state_t      w_state_nx;
    logic [7:0]  r_idx;
    logic [7:0]  w_idx_nx;
    logic [7:0]  r_page;
    logic [7:0]  w_page_nx;
    logic        r_parity;
    logic        r_rdy;
    logic        w_rdy_nx;
    logic        r_active;
    logic        w_active_nx;
    logic [15:0] r_addr;
    logic [15:0] w_addr_nx;
    logic        r_rnw;
    logic        w_rnw_nx;
    logic [7:0]  r_db;      // doubles as the get/put byte buffer
    logic [7:0]  w_db_nx;

    // Get/put parity: free-running toggle, 0 = get cycle, 1 = put cycle.
    always_ff @(posedge CLK or negedge n_RES) begin
        if (!n_RES) begin
            r_parity <= 1'b0;
        end else begin
            r_parity <= ~r_parity;
        end
    end

    // Next state and next registered outputs; every value holds by default.
    always_comb begin
        w_state_nx  = r_state;
        w_idx_nx    = r_idx;
        w_page_nx   = r_page;
        w_rdy_nx    = r_rdy;
        w_active_nx = r_active;
        w_addr_nx   = r_addr;
        w_rnw_nx    = r_rnw;
        w_db_nx     = r_db;
        case (r_state)
            ST_IDLE: begin
                if (W4014) begin
                    w_state_nx = ST_HALT;
                    w_page_nx  = DB_in;
                    w_rdy_nx   = 1'b0;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_HALT: begin
                // CPU write cycles cannot be stolen; wait for a read cycle.
                if (RnW_fromcore) begin
                    w_active_nx = 1'b1;
                    w_rnw_nx    = 1'b1;
                    // Current parity 1 means the next cycle is a get cycle.
                    if (r_parity) begin
                        w_state_nx = ST_GET;
                        w_addr_nx  = {r_page, r_idx};
                    end else begin
                        w_state_nx = ST_ALIGN;
                    end
                end else begin
                    w_state_nx = ST_HALT;
                end
            end
            ST_ALIGN: begin
                w_state_nx = ST_GET;
                w_addr_nx  = {r_page, r_idx};
                w_rnw_nx   = 1'b1;
            end
            ST_GET: begin
                w_state_nx = ST_PUT;
                w_db_nx    = DB_in;
                w_addr_nx  = OAM_PORT;
                w_rnw_nx   = 1'b0;
            end
            ST_PUT: begin
                if (r_idx == LAST_IDX) begin
                    w_state_nx  = ST_IDLE;
                    w_idx_nx    = 8'd0;
                    w_rdy_nx    = 1'b1;
                    w_active_nx = 1'b0;
                    w_rnw_nx    = 1'b1;
                end else begin
                    w_state_nx = ST_GET;
                    w_idx_nx   = r_idx + 8'd1;
                    w_addr_nx  = {r_page, r_idx + 8'd1};
                    w_rnw_nx   = 1'b1;
                end
            end
            default: begin
                w_state_nx  = ST_IDLE;
                w_idx_nx    = 8'd0;
                w_rdy_nx    = 1'b1;
                w_active_nx = 1'b0;
                w_rnw_nx    = 1'b1;
            end
        endcase
    end

    // State, counters and output registers.
    always_ff @(posedge CLK or negedge n_RES) begin
        if (!n_RES) begin
            r_state  <= ST_IDLE;
            r_idx    <= 8'd0;
            r_page   <= 8'd0;
            r_rdy    <= 1'b1;
            r_active <= 1'b0;
            r_addr   <= 16'h0000;
            r_rnw    <= 1'b1;
            r_db     <= 8'h00;
        end else begin
            r_state  <= w_state_nx;
            r_idx    <= w_idx_nx;
            r_page   <= w_page_nx;
            r_rdy    <= w_rdy_nx;
            r_active <= w_active_nx;
            r_addr   <= w_addr_nx;
            r_rnw    <= w_rnw_nx;
            r_db     <= w_db_nx;
        end
    end

    assign RDY        = r_rdy;
    assign DMA_Active = r_active;
    assign DMA_Addr   = r_addr;
    assign DMA_RnW    = r_rnw;
    assign DB_out     = r_db;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl. Source memory returns addr[7:0]^0x5A;
// a negedge monitor tallies bus activity during each transfer.
module tb_oam_dma_ctrl;

    logic        CLK = 1'b0;
    logic        n_RES;
    logic        W4014;
    logic [7:0]  DB_in;
    logic        RnW_fromcore;
    logic        RDY;
    logic        DMA_Active;
    logic [15:0] DMA_Addr;
    logic        DMA_RnW;
    logic [7:0]  DB_out;

    logic        dsel;      // 1: bench drives page byte onto DB_in
    logic [7:0]  pg;

    int n_checks = 0;
    int n_errors = 0;
    int cyc;                // edges since reset release; parity = cyc[0]

    // Monitor tallies
    bit          mon_en = 1'b0;
    int          act_cnt, put_cnt, bad_data, bad_src, first_par, prev_par;
    logic [15:0] prev_addr;
    logic [7:0]  exp_page;

    oam_dma_ctrl dut (
        .CLK          (CLK),
        .n_RES        (n_RES),
        .W4014        (W4014),
        .DB_in        (DB_in),
        .RnW_fromcore (RnW_fromcore),
        .RDY          (RDY),
        .DMA_Active   (DMA_Active),
        .DMA_Addr     (DMA_Addr),
        .DMA_RnW      (DMA_RnW),
        .DB_out       (DB_out)
    );

    always #5 CLK = ~CLK;

    assign DB_in = dsel ? pg : (DMA_Addr[7:0] ^ 8'h5A);

    always @(posedge CLK or negedge n_RES) begin
        if (!n_RES) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge CLK) begin
        if (mon_en && n_RES) begin
            if (DMA_Active) act_cnt++;
            if (DMA_Active && !DMA_RnW) begin
                if (DMA_Addr != 16'h2004 || DB_out != (put_cnt[7:0] ^ 8'h5A)) bad_data++;
                if (prev_addr != {exp_page, put_cnt[7:0]}) bad_src++;
                if (put_cnt == 0) first_par = prev_par;
                put_cnt++;
            end
            prev_addr = DMA_Addr;
            prev_par  = int'(cyc[0]);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Full transfer. want_align selects strobe timing so that an ALIGN cycle
    // is (1) or is not (0) needed after halt_wr CPU write cycles.
    // mode: 0 plain, 1 stray W4014 page 0x07 mid-transfer, 2 W4014 on final put.
    task automatic do_xfer(input logic [7:0] page, input int want_align,
                           input int halt_wr, input int mode);
        int e_start;
        int len;
        bit injected;
        injected = 1'b0;
        tick();
        if ((cyc % 2) != ((want_align + halt_wr) % 2)) tick();
        act_cnt = 0; put_cnt = 0; bad_data = 0; bad_src = 0;
        first_par = -1; prev_par = 0; prev_addr = 16'h0000;
        exp_page = page;
        mon_en = 1'b1;
        W4014 = 1'b1; dsel = 1'b1; pg = page;
        RnW_fromcore = (halt_wr > 0) ? 1'b0 : 1'b1;
        tick();
        W4014 = 1'b0; dsel = 1'b0;
        e_start = cyc;
        check("rdy_low", {31'd0, RDY}, 32'd0);
        check("halt_idle", {31'd0, DMA_Active}, 32'd0);
        repeat (halt_wr) tick();
        RnW_fromcore = 1'b1;
        len = 700;
        for (int i = 0; i < 700; i++) begin
            tick();
            W4014 = 1'b0; dsel = 1'b0;
            if (RDY) begin
                len = cyc - e_start;
                break;
            end
            if (!injected && DMA_Active && !DMA_RnW &&
                ((mode == 1 && put_cnt == 40) || (mode == 2 && put_cnt == 255))) begin
                W4014 = 1'b1; dsel = 1'b1; pg = (mode == 1) ? 8'h07 : 8'h09;
                injected = 1'b1;
            end
        end
        W4014 = 1'b0; dsel = 1'b0;
        repeat (4) tick();
        mon_en = 1'b0;
        check("len", len, 513 + want_align + halt_wr);
        check("puts", put_cnt, 256);
        check("data", bad_data, 0);
        check("src", bad_src, 0);
        check("active", act_cnt, 512 + want_align);
        check("get_par", first_par, 0);
        check("rdy_end", {31'd0, RDY}, 32'd1);
        check("act_end", {31'd0, DMA_Active}, 32'd0);
        check("addr_hold", {16'd0, DMA_Addr}, 32'h2004);
        check("db_hold", {24'd0, DB_out}, 32'h000000A5);
    endtask

    initial begin
        int puts;
        n_RES = 1'b0; W4014 = 1'b0; RnW_fromcore = 1'b1; dsel = 1'b0; pg = 8'h00;
        #23 n_RES = 1'b1;
        repeat (10) tick();
        check("rst_rdy",  {31'd0, RDY}, 32'd1);
        check("rst_act",  {31'd0, DMA_Active}, 32'd0);
        check("rst_rnw",  {31'd0, DMA_RnW}, 32'd1);
        check("rst_addr", {16'd0, DMA_Addr}, 32'h0000);
        check("rst_db",   {24'd0, DB_out}, 32'h00);

        do_xfer(8'h02, 0, 0, 0);
        do_xfer(8'h02, 1, 0, 0);
        do_xfer(8'h11, 0, 3, 0);
        do_xfer(8'h03, 0, 0, 1);
        do_xfer(8'h0A, 1, 0, 2);

        // Reset in the middle of a transfer, at the 100th put.
        tick();
        W4014 = 1'b1; dsel = 1'b1; pg = 8'h06;
        tick();
        W4014 = 1'b0; dsel = 1'b0;
        puts = 0;
        for (int i = 0; i < 400 && puts < 100; i++) begin
            tick();
            if (DMA_Active && !DMA_RnW) puts++;
        end
        check("puts_before_rst", puts, 100);
        #3 n_RES = 1'b0;
        #1;
        check("mid_rst_rdy",  {31'd0, RDY}, 32'd1);
        check("mid_rst_act",  {31'd0, DMA_Active}, 32'd0);
        check("mid_rst_rnw",  {31'd0, DMA_RnW}, 32'd1);
        check("mid_rst_addr", {16'd0, DMA_Addr}, 32'h0000);
        check("mid_rst_db",   {24'd0, DB_out}, 32'h00);
        #2 n_RES = 1'b1;
        repeat (2) tick();
        do_xfer(8'h04, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
